// File: rtl/zl_reset_pkg.sv
// Shared definitions for the staged reset sequencer.
//   seq_state_t : sequencer state encoding (ASSERT=0, RELEASE=1, DONE=2)
//   CAUSE_*     : last_cause codes ({sw, ext} bit order)
//   max_int     : elaboration-time helper for counter sizing
//   cause_code  : maps the two request sources onto a cause code
package zl_reset_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } seq_state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_SW   = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] cause_code(input logic sw, input logic ext);
    logic [1:0] code;
    case ({sw, ext})
      2'b01:   code = CAUSE_EXT;
      2'b10:   code = CAUSE_SW;
      2'b11:   code = CAUSE_BOTH;
      default: code = CAUSE_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/zl_reset_seq_chk.sv
// Property checker for the reset sequencer's internal invariants.
//   clk, rst   : sequencer clock and block reset
//   cnt, idx   : sequencer counters
//   out_rst_n  : staged reset outputs
//   seq_done   : completion flag
module zl_reset_seq_chk #(
  parameter int N_OUT   = 4,
  parameter int CNT_W   = 5,
  parameter int IDX_W   = 3,
  parameter int CNT_MAX = 16
) (
  input logic             clk,
  input logic             rst,
  input logic [CNT_W-1:0] cnt,
  input logic [IDX_W-1:0] idx,
  input logic [N_OUT-1:0] out_rst_n,
  input logic             seq_done
);

  localparam int TW = N_OUT + 1;

  logic [TW-1:0] therm;
  assign therm = {1'b0, out_rst_n};

  // A thermometer word 2^k-1 has no bit in common with its successor.
  a_thermometer: assert property (@(posedge clk) disable iff (rst)
    ((therm & (therm + TW'(1))) == '0));

  a_cnt_bound: assert property (@(posedge clk) disable iff (rst)
    (cnt <= CNT_W'(CNT_MAX)));

  a_idx_bound: assert property (@(posedge clk) disable iff (rst)
    (idx <= IDX_W'(N_OUT)));

  a_done_all_released: assert property (@(posedge clk) disable iff (rst)
    (seq_done == (&out_rst_n)));

endmodule

// File: rtl/zl_sync_ff.sv
// Multi-flop synchronizer for a single-bit asynchronous input.
//   clk : sampling clock
//   rst : synchronous active-high reset, loads every stage with RST_VAL
//   d   : asynchronous input
//   q   : synchronized output (last stage)
module zl_sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the input through the chain; reset fills it with RST_VAL.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/zl_reset_seq.sv
// Staged reset sequencer. Holds all outputs asserted while any request is
// present and for HOLD_CYCLES request-free cycles afterwards, then releases
// out_rst_n one bit at a time, STAGE_GAP cycles apart, bit 0 first.
//   clk        : sole clock
//   rst        : synchronous active-high block reset
//   ext_rst_n  : asynchronous active-low external reset request
//   sw_rst_req : synchronous active-high software reset request
//   out_rst_n  : active-low staged resets (thermometer-coded)
//   seq_done   : high once every stage is released
//   last_cause : 01 ext, 10 sw, 11 both, for the most recent request
module zl_reset_seq
  import zl_reset_pkg::*;
#(
  parameter int N_OUT       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_rst_n,
  input  logic             sw_rst_req,
  output logic [N_OUT-1:0] out_rst_n,
  output logic             seq_done,
  output logic [1:0]       last_cause
);

  localparam int CNT_MAX = max_int(HOLD_CYCLES, STAGE_GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(N_OUT + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_OUT - 1);
  localparam bit               SINGLE    = (N_OUT == 1);

  logic             ext_sync;
  logic             ext_req;
  logic             req_active;

  seq_state_t       state;
  seq_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [N_OUT-1:0] out_next;
  logic             done_next;
  logic [1:0]       cause_next;

  // Block reset forces the chain to 0, i.e. an active external request,
  // so the hold count cannot start until ext_rst_n has been seen high
  // through the whole chain.
  zl_sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_rst_n),
    .q   (ext_sync)
  );

  assign ext_req    = ~ext_sync;
  assign req_active = ext_req | sw_rst_req;

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ASSERT;
      cnt        <= '0;
      idx        <= '0;
      out_rst_n  <= '0;
      seq_done   <= 1'b0;
      last_cause <= CAUSE_NONE;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      idx        <= idx_next;
      out_rst_n  <= out_next;
      seq_done   <= done_next;
      last_cause <= cause_next;
    end
  end

  // Next-state, counter and output logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    out_next   = out_rst_n;
    done_next  = seq_done;
    cause_next = last_cause;

    if (req_active) begin
      // Any request restarts the sequence from scratch, whatever the state.
      state_next = ST_ASSERT;
      cnt_next   = '0;
      idx_next   = '0;
      out_next   = '0;
      done_next  = 1'b0;
      cause_next = cause_code(sw_rst_req, ext_req);
    end else begin
      case (state)
        ST_ASSERT: begin
          out_next  = '0;
          done_next = 1'b0;
          if (cnt == HOLD_LAST) begin
            cnt_next    = '0;
            idx_next    = IDX_W'(1);
            out_next[0] = 1'b1;
            if (SINGLE) begin
              state_next = ST_DONE;
              done_next  = 1'b1;
            end else begin
              state_next = ST_RELEASE;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt == GAP_LAST) begin
            cnt_next = '0;
            idx_next = idx + IDX_W'(1);
            // idx always names the lowest still-asserted bit, so setting it
            // keeps the word thermometer-coded.
            for (int k = 0; k < N_OUT; k++) begin
              if (IDX_W'(k) == idx) begin
                out_next[k] = 1'b1;
              end else begin
                out_next[k] = out_rst_n[k];
              end
            end
            if (idx == IDX_LAST) begin
              state_next = ST_DONE;
              done_next  = 1'b1;
            end else begin
              state_next = ST_RELEASE;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end

        ST_DONE: begin
          cnt_next  = '0;
          out_next  = '1;
          done_next = 1'b1;
        end

        default: begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
          idx_next   = '0;
          out_next   = '0;
          done_next  = 1'b0;
        end
      endcase
    end
  end

  zl_reset_seq_chk #(
    .N_OUT   (N_OUT),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W),
    .CNT_MAX (CNT_MAX)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .cnt       (cnt),
    .idx       (idx),
    .out_rst_n (out_rst_n),
    .seq_done  (seq_done)
  );

endmodule

// File: tb/tb_zl_reset_seq.sv
// Self-checking bench for zl_reset_seq. Three instances share one set of
// inputs: defaults (a), N_OUT=1/HOLD=1/GAP=1 (b) and N_OUT=8/SYNC=3/HOLD=4/
// GAP=3 (c). The reference model only tracks how many consecutive
// request-free edges each instance has seen and derives the released stage
// count arithmetically from that.
module tb_zl_reset_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       ext_rst_n;
  logic       sw_rst_req;
  logic [3:0] out_a;
  logic       done_a;
  logic [1:0] cause_a;
  logic [0:0] out_b;
  logic       done_b;
  logic [1:0] cause_b;
  logic [7:0] out_c;
  logic       done_c;
  logic [1:0] cause_c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  zl_reset_seq dut_a (
    .clk(clk), .rst(rst), .ext_rst_n(ext_rst_n), .sw_rst_req(sw_rst_req),
    .out_rst_n(out_a), .seq_done(done_a), .last_cause(cause_a)
  );

  zl_reset_seq #(.N_OUT(1), .SYNC_STAGES(2), .HOLD_CYCLES(1), .STAGE_GAP(1)) dut_b (
    .clk(clk), .rst(rst), .ext_rst_n(ext_rst_n), .sw_rst_req(sw_rst_req),
    .out_rst_n(out_b), .seq_done(done_b), .last_cause(cause_b)
  );

  zl_reset_seq #(.N_OUT(8), .SYNC_STAGES(3), .HOLD_CYCLES(4), .STAGE_GAP(3)) dut_c (
    .clk(clk), .rst(rst), .ext_rst_n(ext_rst_n), .sw_rst_req(sw_rst_req),
    .out_rst_n(out_c), .seq_done(done_c), .last_cause(cause_c)
  );

  // ---------------- reference model ----------------
  // ecnt: edges since the last rst edge. samp[e]: ext_rst_n seen at edge e.
  // q_*: consecutive request-free edges. cause_*: expected last_cause.
  int       ecnt;
  bit       samp [0:1023];
  int       q_ab;
  int       q_c;
  bit [1:0] cause_ab_m;
  bit [1:0] cause_c_m;

  // An ext_rst_n level sampled at edge e-s is what the request logic acts on
  // at edge e; before that much history exists the request is still active.
  function automatic bit ext_req_at(input int e, input int s);
    return (e - s >= 1) ? !samp[e - s] : 1'b1;
  endfunction

  function automatic int rel_count(input int q, input int n, input int h, input int g);
    int r;
    if (q < h) return 0;
    r = 1 + (q - h) / g;
    return (r > n) ? n : r;
  endfunction

  function automatic logic [7:0] mask(input int r);
    return 8'((1 << r) - 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ecnt       <= 0;
      q_ab       <= 0;
      q_c        <= 0;
      cause_ab_m <= 2'b00;
      cause_c_m  <= 2'b00;
    end else begin
      ecnt <= ecnt + 1;
      samp[ecnt + 1] <= ext_rst_n;
      q_ab <= (sw_rst_req || ext_req_at(ecnt + 1, 2)) ? 0 : q_ab + 1;
      q_c  <= (sw_rst_req || ext_req_at(ecnt + 1, 3)) ? 0 : q_c + 1;
      if (sw_rst_req || ext_req_at(ecnt + 1, 2))
        cause_ab_m <= {sw_rst_req, ext_req_at(ecnt + 1, 2)};
      if (sw_rst_req || ext_req_at(ecnt + 1, 3))
        cause_c_m <= {sw_rst_req, ext_req_at(ecnt + 1, 3)};
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", name, ecnt, act, exp);
    end
  endtask

  task automatic cycle_check();
    logic [7:0] m;
    m = mask(rel_count(q_ab, 4, 16, 8));
    check("a_out", 32'(out_a), 32'(m[3:0]));
    check("a_done", 32'(done_a), 32'(rel_count(q_ab, 4, 16, 8) == 4));
    check("a_cause", 32'(cause_a), 32'(cause_ab_m));
    m = mask(rel_count(q_ab, 1, 1, 1));
    check("b_out", 32'(out_b), 32'(m[0]));
    check("b_done", 32'(done_b), 32'(rel_count(q_ab, 1, 1, 1) == 1));
    check("b_cause", 32'(cause_b), 32'(cause_ab_m));
    m = mask(rel_count(q_c, 8, 4, 3));
    check("c_out", 32'(out_c), 32'(m));
    check("c_done", 32'(done_c), 32'(rel_count(q_c, 8, 4, 3) == 8));
    check("c_cause", 32'(cause_c), 32'(cause_c_m));
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
  endtask

  task automatic wait_edge(input int k);
    int guard;
    guard = 0;
    while (ecnt != k && guard < 2000) begin
      tick();
      guard++;
    end
    if (ecnt != k) begin
      tests++;
      fails++;
      $display("FAIL wait_edge: reached edge %0d, wanted %0d", ecnt, k);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst        = 1'b1;
    ext_rst_n  = 1'b1;
    sw_rst_req = 1'b0;
    tick();
    tick();
    check("rst_out_a", 32'(out_a), 32'h0);
    check("rst_done_a", 32'(done_a), 32'h0);
    check("rst_cause_a", 32'(cause_a), 32'h0);
    check("rst_out_c", 32'(out_c), 32'h0);
    rst = 1'b0;

    // Default release timing, then a one-cycle software pulse.
    wait_edge(17); check("hold_17", 32'(out_a), 32'h0);
    wait_edge(18); check("rel0_18", 32'(out_a), 32'h1);
    wait_edge(26); check("rel1_26", 32'(out_a), 32'h3);
    wait_edge(30); sw_rst_req = 1'b1;
    wait_edge(31); sw_rst_req = 1'b0;
    check("sw_out_31", 32'(out_a), 32'h0);
    check("sw_done_31", 32'(done_a), 32'h0);
    check("sw_cause_31", 32'(cause_a), 32'h2);
    wait_edge(46); check("sw_hold_46", 32'(out_a), 32'h0);
    wait_edge(47); check("sw_rel_47", 32'(out_a), 32'h1);

    // External request for 50 cycles while DONE.
    wait_edge(75); ext_rst_n = 1'b0;
    wait_edge(77); check("ext_pre_77", 32'(out_a), 32'hF);
    check("ext_done_77", 32'(done_a), 32'h1);
    wait_edge(78); check("ext_out_78", 32'(out_a), 32'h0);
    check("ext_cause_78", 32'(cause_a), 32'h1);
    wait_edge(125); ext_rst_n = 1'b1;
    wait_edge(142); check("ext_hold_142", 32'(out_a), 32'h0);
    wait_edge(143); check("ext_rel_143", 32'(out_a), 32'h1);
    check("ext_cause_143", 32'(cause_a), 32'h1);

    // Software pulse coinciding with the first synchronized ext request.
    wait_edge(150); ext_rst_n = 1'b0;
    wait_edge(152); sw_rst_req = 1'b1;
    wait_edge(153); sw_rst_req = 1'b0;
    check("both_cause_153", 32'(cause_a), 32'h3);
    check("both_out_153", 32'(out_a), 32'h0);
    wait_edge(160); ext_rst_n = 1'b1;
    wait_edge(178); check("both_rel_178", 32'(out_a), 32'h1);
    wait_edge(188); check("idx2_188", 32'(out_a), 32'h3);

    // Block reset mid-release, then full default timing from rst release.
    rst = 1'b1;
    tick();
    check("mid_rst_out_a", 32'(out_a), 32'h0);
    check("mid_rst_done_a", 32'(done_a), 32'h0);
    check("mid_rst_cause_a", 32'(cause_a), 32'h0);
    check("mid_rst_out_b", 32'(out_b), 32'h0);
    check("mid_rst_out_c", 32'(out_c), 32'h0);
    rst = 1'b0;
    wait_edge(2);  check("b_hold_2", 32'(out_b), 32'h0);
    wait_edge(3);  check("b_rel_3", 32'(out_b), 32'h1);
    check("b_done_3", 32'(done_b), 32'h1);
    wait_edge(17); check("r_hold_17", 32'(out_a), 32'h0);
    wait_edge(18); check("r_rel0_18", 32'(out_a), 32'h1);
    wait_edge(26); check("r_rel1_26", 32'(out_a), 32'h3);
    wait_edge(27); check("c_rel_27", 32'(out_c), 32'h7F);
    check("c_done_27", 32'(done_c), 32'h0);
    wait_edge(28); check("c_rel_28", 32'(out_c), 32'hFF);
    check("c_done_28", 32'(done_c), 32'h1);
    wait_edge(34); check("r_rel2_34", 32'(out_a), 32'h7);
    wait_edge(41); check("r_pre_41", 32'(out_a), 32'h7);
    check("r_done_41", 32'(done_a), 32'h0);
    wait_edge(42); check("r_rel3_42", 32'(out_a), 32'hF);
    check("r_done_42", 32'(done_a), 32'h1);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
